// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
//
// Conditions active-low pushbutton pins. Each channel works on its own:
//   1. A two-flop synchroniser brings the asynchronous pin into the i_clk domain.
//   2. A per-channel STABLE/COUNTING FSM accepts a new value only after it has
//      held for DEBOUNCE_CYCLES consecutive cycles.
//   3. The block drives a clean active-high level and one-cycle press/release
//      pulses.
//
// Optional feature: define BUTTON_DEBOUNCE_TOGGLE_EN to add a press-toggled
// latch per channel on o_toggle. When the macro is not defined, o_toggle is
// tied to 0 and no toggle flops are built.
//
// Parameters
//   N_CH            number of independent channels (default 2)
//   DEBOUNCE_CYCLES consecutive cycles a new value must hold (>= 2)
//
// Ports
//   i_clk           system clock
//   i_rst           synchronous, active-high reset
//   i_btn_n         raw pins, active-low (0 = pressed), asynchronous to i_clk
//   o_level         debounced state, 1 = pressed
//   o_press         one-cycle pulse on each accepted press
//   o_release       one-cycle pulse on each accepted release
//   o_toggle        press-toggled latch (0 when BUTTON_DEBOUNCE_TOGGLE_EN is undefined)
//   o_dbg_counting  per-channel FSM state, 1 = COUNTING, 0 = STABLE
//
// Handshake: there is no handshake. o_press and o_release are qualifier-free
// one-cycle strobes that are valid in the cycle they are high. The consumer
// cannot stall them.
// -----------------------------------------------------------------------------
module button_debounce #(
    parameter int N_CH            = 2,
    parameter int DEBOUNCE_CYCLES = 160000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [N_CH-1:0] i_btn_n,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_press,
    output logic [N_CH-1:0] o_release,
    output logic [N_CH-1:0] o_toggle,
    output logic [N_CH-1:0] o_dbg_counting
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } state_t;

    // Synchroniser. Both stages reset to 1, the released pin level, so that
    // leaving reset never looks like a fresh press edge.
    logic [N_CH-1:0] r_s1;
    logic [N_CH-1:0] r_s2;
    logic [N_CH-1:0] w_p;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1 <= '1;
            r_s2 <= '1;
        end else begin
            r_s1 <= i_btn_n;
            r_s2 <= r_s1;
        end
    end

    // Active-high sampled value
    assign w_p = ~r_s2;

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_ch
            state_t        r_state;
            logic [CW-1:0] r_cnt;
            logic          r_level;
            logic          r_press;
            logic          r_release;

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_state   <= ST_STABLE;
                    r_cnt     <= '0;
                    r_level   <= 1'b0;
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                end else begin
                    // Pulses last one cycle unless re-armed below
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                    case (r_state)
                        ST_STABLE: begin
                            if (w_p[g] != r_level) begin
                                r_state <= ST_COUNTING;
                                r_cnt   <= CW'(1);
                            end
                        end
                        ST_COUNTING: begin
                            if (w_p[g] == r_level) begin
                                // A bounce: drop the partial count and leave outputs alone
                                r_state <= ST_STABLE;
                                r_cnt   <= '0;
                            end else if (r_cnt == CNT_LAST) begin
                                // The value has held long enough. Accept it and fire
                                // the pulse that matches its direction.
                                r_state   <= ST_STABLE;
                                r_cnt     <= '0;
                                r_level   <= w_p[g];
                                r_press   <= w_p[g];
                                r_release <= ~w_p[g];
                            end else begin
                                r_cnt <= r_cnt + CW'(1);
                            end
                        end
                        default: begin
                            r_state <= ST_STABLE;
                            r_cnt   <= '0;
                        end
                    endcase
                end
            end

            assign o_level[g]        = r_level;
            assign o_press[g]        = r_press;
            assign o_release[g]      = r_release;
            assign o_dbg_counting[g] = (r_state == ST_COUNTING);

`ifdef BUTTON_DEBOUNCE_TOGGLE_EN
            // The toggle flips on the same edge that raises o_press
            logic r_toggle;

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_toggle <= 1'b0;
                end else if ((r_state == ST_COUNTING) && (w_p[g] != r_level) &&
                             (r_cnt == CNT_LAST) && w_p[g]) begin
                    r_toggle <= ~r_toggle;
                end
            end

            assign o_toggle[g] = r_toggle;
`else
            assign o_toggle[g] = 1'b0;
`endif
        end
    endgenerate

endmodule

// File: doc/button_debounce.md
# button_debounce

Per-channel input conditioner for the board's active-low pushbuttons (pins with internal pull-ups). It sits directly upstream of the top-level LED/logic stage. Each raw pin is synchronised into the `CLK` domain and debounced with a stability counter. The block emits a clean active-high pressed level plus one-cycle press and release pulses, so downstream logic never sees metastable or bouncing inputs.

## Interface
- `N_CH`, default 2: number of independent button channels.
- `DEBOUNCE_CYCLES`, default 160000: consecutive cycles a new value must hold before it is accepted (10 ms at 16 MHz). Must be at least 2. Counter width is `CW = $clog2(DEBOUNCE_CYCLES)`.
- `CLK` in 1: system clock (16 MHz board clock).
- `RST` in 1: synchronous, active-high reset.
- `btn_n` in N_CH: raw pin inputs, active-low (0 = pressed), asynchronous to `CLK`.
- `level` out N_CH: debounced state, 1 = pressed.
- `press` out N_CH: one-cycle pulse on each accepted press.
- `release` out N_CH: one-cycle pulse on each accepted release.
- `toggle` out N_CH: press-toggled latch (see Configuration).

## Operation
Every channel is independent and identical. No state is shared between channels.

**Synchronizer**
- Two-flop chain `s1` then `s2` per bit.
- Both flops reset to 1, which is the released state.
- Sampled value `p = ~s2`.

**Debounce FSM (per channel)**
- STABLE state: `cnt = 0`.
  - If `p == level`, stay in STABLE.
  - If `p != level`, go to COUNTING with `cnt <= 1`.
- COUNTING state:
  - If `p == level`, the event is a bounce. Return to STABLE with `cnt <= 0`. No output change.
  - If `p != level` and `cnt < DEBOUNCE_CYCLES-1`, increment `cnt`.
  - If `p != level` and `cnt == DEBOUNCE_CYCLES-1`, set `level <= p` and `cnt <= 0`, go to STABLE, and fire the pulse.
- Pulse selection: `press <= 1` if the new level is 1, `release <= 1` if it is 0.
- `press` and `release` are registered and deassert on the next edge. They are never asserted together on the same channel.
- `cnt` never exceeds `DEBOUNCE_CYCLES-1`, so there is no wrap-around.

**Reset values**
- `level`, `press`, `release`, `toggle`, `cnt`: all 0.
- FSM: STABLE.
- `s1`, `s2`: 1.

**Boundary behaviour**
- Button held through reset:
  - No pulse appears on release of reset.
  - `press` fires after a full debounce period from the first post-reset sample.
- Reset asserted mid-count: the count is discarded and `level` stays 0.
- Glitch shorter than `DEBOUNCE_CYCLES` cycles at `s2`: no change to any output.
- All channels may switch on the same edge; each pulses independently.

## Timing
- Let edge k be the first `CLK` edge that samples a new stable pin value into `s1`.
  - `s2` updates on edge k+1.
  - `cnt` counts on edges k+2 through k+1+DEBOUNCE_CYCLES.
  - `level` and the pulse update on edge k+1+DEBOUNCE_CYCLES.
- Total latency: DEBOUNCE_CYCLES+1 edges after first capture.
- Pulse width is exactly one cycle.
- Minimum spacing between two accepted transitions on one channel is DEBOUNCE_CYCLES cycles.
- All outputs are registered. There are no combinational paths from `btn_n` to any output.

## Configuration
- Macro: `BUTTON_DEBOUNCE_TOGGLE_EN`.
- Defined:
  - `toggle[i]` inverts on every edge where `press[i]` is set (it changes together with `press`).
  - Reset value is 0.
  - `release` has no effect on `toggle`.
- Undefined:
  - `toggle` is driven constant 0.
  - No toggle flops are generated.
  - All other behaviour is identical.

## Test plan
All scenarios use `DEBOUNCE_CYCLES = 4` and `N_CH = 2`.
- **Reset:** hold `RST` for 3 cycles with `btn_n = 2'b11` -> all outputs 0; no pulses for 10 cycles after `RST` drops.
- **Clean press on ch0:** drive `btn_n[0]` to 0 and hold -> `level[0]` rises and `press[0]` pulses for exactly 1 cycle, 5 edges after first capture; ch1 outputs stay 0.
- **Bounce rejection:** toggle `btn_n[0]` low for 3 cycles, high for 1, low for 2, then high -> `level[0]` stays 0 and there are no pulses.
- **Release:** from pressed, drive `btn_n[0] = 1` and hold -> `release[0]` pulses once, 5 edges after capture, and `level[0]` falls.
- **Simultaneous events and reset mid-count:**
  - Press both channels on the same cycle -> both `press` bits pulse on the same edge.
  - Repeat the press, but assert `RST` after 2 counting cycles, then release `RST` while still held -> `level` stays 0 through reset, and `press` fires a full 5 edges after the reset is released.
- **Toggle:** with `BUTTON_DEBOUNCE_TOGGLE_EN`, do 3 clean presses on ch1 -> `toggle[1]` goes 1, 0, 1. Without the macro -> `toggle == 0` throughout.
